// File: rtl/wormhole_out_arbiter_pkg.sv
// Shared sizing constants and state type for the per-output wormhole allocator.
package wormhole_out_arbiter_pkg;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned CREDITS      = 4;
  localparam int unsigned CRED_W       = 3;
  localparam int unsigned OWN_W        = $clog2(N_REQ);
  // Position of the tail flag inside the flit header.
  localparam int unsigned HDR_TAIL_BIT = 0;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

endpackage

// File: rtl/wormhole_out_arbiter_if.sv
// Request/grant channel between the input ports and one output allocator.
interface wormhole_out_arbiter_if;
  import wormhole_out_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] tail;
  logic             credit_in;
  logic [N_REQ-1:0] gnt;
  logic             ena;

  modport master (
    output req,
    output tail,
    output credit_in,
    input  gnt,
    input  ena
  );

  modport slave (
    input  req,
    input  tail,
    input  credit_in,
    output gnt,
    output ena
  );

endinterface

// File: rtl/wormhole_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module wormhole_out_arbiter_rr_pick
  import wormhole_out_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             any
);

  logic [OWN_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = OWN_W'((32'(ptr) + k) % N_REQ);
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_out_arbiter.sv
// Output-channel allocator: round-robin among inputs, grant held head-to-tail,
// and transfers gated by downstream credits.
module wormhole_out_arbiter
  import wormhole_out_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  wormhole_out_arbiter_if.slave     bus,
  output logic [CRED_W-1:0]         credits,
  output logic                      locked,
  output logic [OWN_W-1:0]          owner,
  output logic                      cred_err
);

  arb_state_e        state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  ptr_q, ptr_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              cred_err_q, cred_err_d;

  logic [N_REQ-1:0]  pick;
  logic              pick_any;
  logic [N_REQ-1:0]  gnt;
  logic              ena;
  logic              has_credit;
  logic [OWN_W-1:0]  grant_idx;
  logic              grant_tail;

  wormhole_out_arbiter_rr_pick u_rr_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  assign has_credit = (credits_q != '0);

  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (state_q == StLocked) begin
        // Non-owners are ignored even while the owner has nothing to send.
        gnt[owner_q] = bus.req[owner_q] & has_credit;
      end else if (pick_any && has_credit) begin
        gnt = pick;
      end
    end
  end

  assign ena     = |gnt;
  assign bus.gnt = gnt;
  assign bus.ena = ena;

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) grant_idx = OWN_W'(i);
    end
    grant_tail = |(gnt & bus.tail);
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    credits_d  = credits_q;
    cred_err_d = cred_err_q;

    if (ena) begin
      if (grant_tail) begin
        state_d = StIdle;
        ptr_d   = (grant_idx == OWN_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d = StLocked;
        owner_d = grant_idx;
      end
    end

    unique case ({ena, bus.credit_in})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        // Excess credit means the downstream bookkeeping is broken; saturate and flag.
        if (credits_q == CRED_W'(CREDITS)) cred_err_d = 1'b1;
        else                               credits_d  = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      ptr_q      <= '0;
      credits_q  <= CRED_W'(CREDITS);
      cred_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      cred_err_q <= cred_err_d;
    end
  end

  assign credits  = credits_q;
  assign locked   = (state_q == StLocked);
  assign owner    = owner_q;
  assign cred_err = cred_err_q;

endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// Directed bench for wormhole_out_arbiter with hand-computed expectations.
module tb_wormhole_out_arbiter;
  import wormhole_out_arbiter_pkg::*;

  logic              clk;
  logic              reset;
  logic [CRED_W-1:0] credits;
  logic              locked;
  logic [OWN_W-1:0]  owner;
  logic              cred_err;

  int unsigned n_total;
  int unsigned n_pass;

  wormhole_out_arbiter_if bus ();

  wormhole_out_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .credits  (credits),
    .locked   (locked),
    .owner    (owner),
    .cred_err (cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] t, input logic c);
    bus.req       = r;
    bus.tail      = t;
    bus.credit_in = c;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rr_exp [8];
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    bus.req = '0;
    bus.tail = '0;
    bus.credit_in = 1'b0;

    // Reset: grants forced low even with requests present.
    tick();
    drive(4'b1111, 4'b1111, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_ena", 32'(bus.ena), 32'h0);
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cred_err", 32'(cred_err), 32'd0);
    tick();
    reset = 1'b0;

    // Round-robin over all single-flit requesters; credit returned with each transfer.
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      chk($sformatf("rr_gnt%0d", i), 32'(bus.gnt), 32'(rr_exp[i]));
      chk($sformatf("rr_ena%0d", i), 32'(bus.ena), 32'd1);
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b0);
    chk("rr_credits", 32'(credits), 32'd4);
    chk("rr_locked", 32'(locked), 32'd0);
    tick();

    // Wormhole lock: input 0 sends head, body, tail while input 1 waits.
    drive(4'b0011, 4'b0000, 1'b1);
    chk("wh_gnt_head", 32'(bus.gnt), 32'h1);
    chk("wh_locked_head", 32'(locked), 32'd0);
    tick();
    drive(4'b0011, 4'b0000, 1'b1);
    chk("wh_gnt_body", 32'(bus.gnt), 32'h1);
    chk("wh_locked_body", 32'(locked), 32'd1);
    chk("wh_owner_body", 32'(owner), 32'd0);
    tick();
    drive(4'b0011, 4'b0001, 1'b1);
    chk("wh_gnt_tail", 32'(bus.gnt), 32'h1);
    chk("wh_locked_tail", 32'(locked), 32'd1);
    tick();
    drive(4'b0010, 4'b0010, 1'b1);
    chk("wh_gnt_next", 32'(bus.gnt), 32'h2);
    chk("wh_locked_next", 32'(locked), 32'd0);
    tick();

    // Owner bubble: lock on input 2, then owner idles while others request.
    drive(4'b0100, 4'b0000, 1'b1);
    chk("ob_gnt_head", 32'(bus.gnt), 32'h4);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1011, 4'b0000, 1'b0);
      chk($sformatf("ob_gnt_bubble%0d", i), 32'(bus.gnt), 32'h0);
      chk($sformatf("ob_ena_bubble%0d", i), 32'(bus.ena), 32'd0);
      chk($sformatf("ob_locked_bubble%0d", i), 32'(locked), 32'd1);
      chk($sformatf("ob_owner_bubble%0d", i), 32'(owner), 32'd2);
      tick();
    end
    drive(4'b1111, 4'b0100, 1'b1);
    chk("ob_gnt_resume", 32'(bus.gnt), 32'h4);
    chk("ob_credits", 32'(credits), 32'd4);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("ob_unlocked", 32'(locked), 32'd0);
    chk("ob_cred_err", 32'(cred_err), 32'd0);
    tick();

    // Credit exhaustion: four grants drain the counter, the fifth is blocked.
    for (int i = 0; i < 5; i++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      chk($sformatf("ce_credits%0d", i), 32'(credits), 32'(4 - i));
      chk($sformatf("ce_gnt%0d", i), 32'(bus.gnt), (i < 4) ? 32'h1 : 32'h0);
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b1);
    chk("ce_gnt_same_cycle_credit", 32'(bus.gnt), 32'h0);
    tick();
    drive(4'b0001, 4'b0001, 1'b0);
    chk("ce_credits_after_return", 32'(credits), 32'd1);
    chk("ce_gnt_after_return", 32'(bus.gnt), 32'h1);
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    chk("ce_credits_drained", 32'(credits), 32'd0);
    tick();

    // Simultaneous transfer and credit return leaves the count unchanged.
    drive(4'b0000, 4'b0000, 1'b0);
    chk("st_credits_pre", 32'(credits), 32'd1);
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    drive(4'b0001, 4'b0001, 1'b1);
    chk("st_credits_two", 32'(credits), 32'd2);
    chk("st_gnt", 32'(bus.gnt), 32'h1);
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    chk("st_credits_hold", 32'(credits), 32'd2);
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    chk("st_credits_full", 32'(credits), 32'd4);
    chk("st_cred_err_clear", 32'(cred_err), 32'd0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("st_credits_sat", 32'(credits), 32'd4);
    chk("st_cred_err_set", 32'(cred_err), 32'd1);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    chk("st_cred_err_sticky", 32'(cred_err), 32'd1);
    tick();

    // Reset mid-packet: lock on input 1 and drain to one credit first.
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      chk($sformatf("rm_gnt%0d", i), 32'(bus.gnt), 32'h2);
      tick();
    end
    drive(4'b0010, 4'b0000, 1'b0);
    chk("rm_locked_pre", 32'(locked), 32'd1);
    chk("rm_owner_pre", 32'(owner), 32'd1);
    chk("rm_credits_pre", 32'(credits), 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_gnt_in_reset", 32'(bus.gnt), 32'h0);
    chk("rm_ena_in_reset", 32'(bus.ena), 32'd0);
    tick();
    reset = 1'b0;
    drive(4'b0110, 4'b0110, 1'b0);
    chk("rm_locked_post", 32'(locked), 32'd0);
    chk("rm_owner_post", 32'(owner), 32'd0);
    chk("rm_credits_post", 32'(credits), 32'd4);
    chk("rm_cred_err_post", 32'(cred_err), 32'd0);
    chk("rm_gnt_post", 32'(bus.gnt), 32'h2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wormhole_out_arbiter.md
Name: wormhole_out_arbiter

Overview:
- Per-output-channel allocator for the 5-port router crossbar. It replaces the stateless rr_arbiter plus busy gating with three things: round-robin arbitration among the 4 non-self input ports, wormhole grant locking from head flit to tail flit, and credit-based flow control against the downstream FIFO.
- One instance sits on each router output (N/E/S/W/L). Its gnt drives the crossbar select and the input-FIFO read, and its ena drives the output-channel enable.

Parameters:
- N_REQ, 4, number of requesting input ports (all directions except the output's own).
- CREDITS, 4, downstream FIFO depth; initial and maximum credit count.
- CRED_W, 3, credit counter width; must satisfy 2^CRED_W > CREDITS.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  req[i]=1: input i has a head-of-line item routed to this output (its FIFO is non-empty and the table matches).
- tail  input  N_REQ  tail[i]=1: input i's head-of-line item is the last flit of its packet (HDR tail bit).
- credit_in  input  1  one-cycle pulse; downstream has freed one slot.
- gnt  output  N_REQ  one-hot or zero; gnt[i]=1 means input i transfers this cycle.
- ena  output  1  output channel write enable; equals |gnt.
- credits  output  CRED_W  current credit count.
- locked  output  1  a packet is in progress (state LOCKED).
- owner  output  2  index of the locked input; valid only when locked=1.
- cred_err  output  1  sticky flag: credit returned while already at CREDITS.

Behaviour:
- Reset values, applied on the clk edge with reset=1:
  - credits=CREDITS, locked=0, owner=0, ptr=0, cred_err=0.
  - gnt=0 and ena=0 are forced combinationally while reset=1.
- State machine: IDLE (locked=0) and LOCKED (locked=1). ptr is the registered round-robin pointer (0..N_REQ-1).
- gnt and ena are combinational from the registers and inputs, with zero latency, matching the crossbar timing.
- IDLE:
  - The candidate is the first i scanning ptr, ptr+1, ... (mod N_REQ) with req[i]=1.
  - gnt[candidate]=1 only if credits>0; otherwise gnt=0.
- LOCKED:
  - gnt[owner]=req[owner] & (credits>0).
  - All other requests are ignored, even if the owner is idle that cycle.
- Transfer means ena=1. On a transfer from input i:
  - If tail[i]=1: next state is IDLE and ptr <= (i+1) mod N_REQ.
  - If tail[i]=0: next state is LOCKED and owner <= i. Stay LOCKED until the owner's tail flit transfers.
- A single-flit packet (head with tail=1) never enters LOCKED.
- ptr changes only on a tail transfer. In IDLE with no transfer, ptr holds.
- Credit counter updates each cycle:
  - transfer & !credit_in: credits-1.
  - !transfer & credit_in: credits+1.
  - Both or neither: unchanged.
- Credit boundaries:
  - credits==0 blocks all grants, including the locked owner.
  - credit_in with credits==CREDITS and no transfer: credits saturate at CREDITS and cred_err <= 1. cred_err stays set until reset.
  - A credit return in the same cycle as the transfer that uses it is legal. At credits==0, a credit_in does not enable a grant in that same cycle; the grant happens the next cycle.
- Reset mid-packet: lock is dropped, ptr=0, credits=CREDITS. The upstream router is reset by the same reset.
- Consistency between inputs: req[i]=0 makes tail[i] a don't-care.

Decomposition:
- Shared defines file holds: N_REQ, CREDITS, CRED_W, and the HDR tail-bit index. Existing `DIRECTIONS, `BITS_DIR and `ADDR_SZ stay where they are.
- One natural sub-module: rr_pick. It is combinational: inputs req[N_REQ] and ptr; outputs one-hot pick and any. It is reused by the IDLE path.
- The router maps local req/gnt indices to direction indices at instantiation, replacing the current rr_arbiter instances.

Test Plan:
- Round-robin fairness:
  - Stimulus: reset, then req=4'b1111, tail=4'b1111, credits ample (credit_in pulsed each cycle after a transfer).
  - Response: gnt sequence 0001,0010,0100,1000,0001; ptr advances 1,2,3,0.
- Wormhole lock:
  - Stimulus: req=4'b0011; input 0 sends 3 flits with tail=0,0,1.
  - Response: gnt=0001 for 3 consecutive cycles and locked=1 after flit 1; input 1 is then granted on the 4th cycle.
- Owner bubble:
  - Stimulus: while LOCKED on owner 2, req=4'b1011 (owner idle) for 2 cycles.
  - Response: gnt=0000, ena=0, locked stays 1; resumes gnt=0100 when req[2] returns.
- Credit exhaustion:
  - Stimulus: CREDITS=4, no credit_in, 5 single-flit requests from input 0.
  - Response: 4 grants, credits 4→0, 5th blocked. credit_in pulse → credits=1, grant the next cycle, credits back to 0.
- Simultaneous transfer and credit return:
  - Stimulus: credits=2, transfer with credit_in in the same cycle.
  - Response: credits stays 2. A credit_in at credits=4 with no transfer gives credits=4 and cred_err=1, held until reset.
- Reset mid-packet:
  - Stimulus: assert reset while locked=1, owner=1, credits=1.
  - Response: next cycle locked=0, owner=0, credits=4, cred_err=0, gnt=0 during reset. After release, req=4'b0110 grants input 1 (ptr=0 scan).
